// File: rtl/rnbip_stack_pkg.sv
// rnbip_stack_pkg: shared states, stack direction codes and frame size (STK_FLAGS_SAVE_EN adds the flags byte).
package rnbip_stack_pkg;
  localparam logic PUSH = 1'b0;
  localparam logic POP  = 1'b1;
  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] PUSH_LO = 4'd1;
  localparam logic [3:0] PUSH_HI = 4'd2;
  localparam logic [3:0] PUSH_FL = 4'd3;
  localparam logic [3:0] POP_FL  = 4'd4;
  localparam logic [3:0] POP_HI  = 4'd5;
  localparam logic [3:0] POP_LO  = 4'd6;
  localparam logic [3:0] CAP     = 4'd7;
  localparam logic [3:0] FIN     = 4'd8;
`ifdef STK_FLAGS_SAVE_EN
  localparam int unsigned FRAME = 3;
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam int unsigned FRAME = 2;
  localparam logic FLAGS_EN = 1'b0;
`endif
endpackage

// File: rtl/stack_depth_ctr.sv
// stack_depth_ctr: byte count of the stack with room/availability checks for one frame.
module stack_depth_ctr
  import rnbip_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [8:0] depth,
  output logic       fits,
  output logic       avail
);
  assign fits  = ({1'b0, depth} + 10'(FRAME)) <= 10'(DEPTH);
  assign avail = depth >= 9'(FRAME);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) depth <= '0;
    else depth <= inc ? depth + 9'd1 : dec ? depth - 9'd1 : depth;
endmodule

// File: rtl/stack_call_seq.sv
// stack_call_seq: CALL/RET byte sequencer for the RNBIP-2 hardware stack; STK_FLAGS_SAVE_EN also saves flags.
module stack_call_seq
  import rnbip_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic [15:0] pc_in,
  input  logic [7:0]  flags_in,
  input  logic [7:0]  stk_rdata,
  output logic        stk_en,
  output logic        stk_rw,
  output logic [7:0]  stk_wdata,
  output logic [15:0] pc_out,
  output logic [7:0]  flags_out,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_unf,
  output logic [8:0]  depth
);
  logic [3:0] state, nxt;
  logic [15:0] pc_q;
  logic [7:0] hi_q;
  logic push, pop, fits, avail, idle;
  assign idle = state == IDLE;
  assign push = state == PUSH_LO || state == PUSH_HI || state == PUSH_FL;
  assign pop  = state == POP_FL || state == POP_HI || state == POP_LO;
  assign stk_en = push || pop;
  assign stk_rw = pop ? POP : PUSH;
  assign busy = !idle;
  assign done = state == FIN;
  stack_depth_ctr #(.DEPTH(DEPTH)) u_depth (
    .clk(clk), .rst_n(rst_n), .inc(push), .dec(pop),
    .depth(depth), .fits(fits), .avail(avail)
  );
  always_comb
    nxt = idle ? (call_req ? (fits ? PUSH_LO : IDLE) :
                  (ret_req && avail) ? (FLAGS_EN ? POP_FL : POP_HI) : IDLE) :
          state == PUSH_LO ? PUSH_HI :
          state == PUSH_HI ? (FLAGS_EN ? PUSH_FL : FIN) :
          state == PUSH_FL ? FIN :
          state == POP_FL  ? POP_HI :
          state == POP_HI  ? POP_LO :
          state == POP_LO  ? CAP :
          state == CAP     ? FIN : IDLE;
`ifdef STK_FLAGS_SAVE_EN
  logic [7:0] fl_q, fl_s;
  assign stk_wdata = state == PUSH_LO ? pc_q[7:0] : state == PUSH_HI ? pc_q[15:8] :
                     state == PUSH_FL ? fl_q : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fl_q      <= '0;
      fl_s      <= '0;
      flags_out <= '0;
    end else begin
      if (idle && call_req) fl_q <= flags_in;
      if (state == POP_HI) fl_s <= stk_rdata;
      if (state == CAP) flags_out <= fl_s;
    end
`else
  logic unused_flags;
  assign unused_flags = ^flags_in;
  assign flags_out = 8'h00;
  assign stk_wdata = state == PUSH_LO ? pc_q[7:0] : state == PUSH_HI ? pc_q[15:8] : 8'h00;
`endif
  // Popped bytes land one cycle after their strobe, so each capture trails its pop state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      pc_q    <= '0;
      hi_q    <= '0;
      pc_out  <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      state   <= nxt;
      err_ovf <= idle && call_req && !fits;
      err_unf <= idle && !call_req && ret_req && !avail;
      if (idle && call_req) pc_q <= pc_in;
      if (state == POP_LO) hi_q <= stk_rdata;
      if (state == CAP) pc_out <= {hi_q, stk_rdata};
    end
endmodule

// File: tb/tb_stack_call_seq.sv
// tb_stack_call_seq: scoreboard bench with a byte-stack RAM model; expectations queued at stimulus time.
module tb_stack_call_seq;
  localparam int DEPTH = 4;
`ifdef STK_FLAGS_SAVE_EN
  localparam int F = 3;
`else
  localparam int F = 2;
`endif
  logic clk = 0, rst_n = 0, call_req = 0, ret_req = 0;
  logic [15:0] pc_in = 0, pc_out;
  logic [7:0] flags_in = 0, stk_rdata, stk_wdata, flags_out;
  logic stk_en, stk_rw, busy, done, err_ovf, err_unf;
  logic [8:0] depth;

  stack_call_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .ret_req(ret_req),
    .pc_in(pc_in), .flags_in(flags_in), .stk_rdata(stk_rdata),
    .stk_en(stk_en), .stk_rw(stk_rw), .stk_wdata(stk_wdata),
    .pc_out(pc_out), .flags_out(flags_out), .busy(busy), .done(done),
    .err_ovf(err_ovf), .err_unf(err_unf), .depth(depth)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:DEPTH-1];
  int sp;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp <= 0;
      stk_rdata <= 8'h00;
    end else if (stk_en) begin
      if (!stk_rw) begin
        mem[sp] <= stk_wdata;
        sp <= sp + 1;
      end else begin
        stk_rdata <= mem[sp-1];
        sp <= sp - 1;
      end
    end

  typedef struct {int kind; logic [15:0] v; logic [7:0] f; logic [8:0] d;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  logic [15:0] exp_pc = 0;
  logic [7:0] exp_fl = 0;
  logic [8:0] exp_d = 0;
  logic [15:0] pcs[$];
  logic [7:0] fls[$];

  // kinds: 0 push, 1 pop, 2 done, 3 overflow, 4 underflow
  always @(negedge clk)
    if (rst_n && (stk_en || done || err_ovf || err_unf)) begin
      automatic int k = stk_en ? (stk_rw ? 1 : 0) : done ? 2 : err_ovf ? 3 : 4;
      automatic ev_t e;
      automatic bit ok;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%0d wdata=%h pc_out=%h depth=%0d", k, stk_wdata, pc_out, depth);
      end else begin
        e = q.pop_front();
        ok = (k == e.kind);
        if (e.kind == 0) ok = ok && stk_wdata == e.v[7:0];
        if (e.kind == 2) ok = ok && pc_out == e.v && flags_out == e.f && depth == e.d;
        if (e.kind >= 3) ok = ok && depth == e.d;
        if (!ok) begin
          errors++;
          $display("FAIL event got kind=%0d wdata=%h pc=%h fl=%h depth=%0d want kind=%0d v=%h fl=%h depth=%0d",
                   k, stk_wdata, pc_out, flags_out, depth, e.kind, e.v, e.f, e.d);
        end
      end
    end

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, g, e);
    end
  endtask

  task automatic wait_evt(input string n, input int lat);
    int got = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done || err_ovf || err_unf) begin
        got = i;
        break;
      end
    end
    chk({n, "_latency"}, got, lat);
  endtask

  task automatic do_call(input logic [15:0] pc, input logic [7:0] fl, input logic both);
    int lat;
    if (int'(exp_d) + F > DEPTH) begin
      q.push_back('{3, 16'h0, 8'h0, exp_d});
      lat = 1;
    end else begin
      q.push_back('{0, {8'h0, pc[7:0]}, 8'h0, 9'h0});
      q.push_back('{0, {8'h0, pc[15:8]}, 8'h0, 9'h0});
      if (F == 3) q.push_back('{0, {8'h0, fl}, 8'h0, 9'h0});
      exp_d = exp_d + 9'(F);
      q.push_back('{2, exp_pc, exp_fl, exp_d});
      pcs.push_back(pc);
      fls.push_back(fl);
      lat = F + 1;
    end
    @(negedge clk);
    call_req = 1; ret_req = both; pc_in = pc; flags_in = fl;
    @(posedge clk); #1;
    call_req = 0; ret_req = 0;
    wait_evt("call", lat);
  endtask

  task automatic do_ret();
    int lat;
    if (int'(exp_d) < F) begin
      q.push_back('{4, 16'h0, 8'h0, exp_d});
      lat = 1;
    end else begin
      for (int i = 0; i < F; i++) q.push_back('{1, 16'h0, 8'h0, 9'h0});
      exp_d = exp_d - 9'(F);
      exp_pc = pcs.pop_back();
`ifdef STK_FLAGS_SAVE_EN
      exp_fl = fls.pop_back();
`else
      void'(fls.pop_back());
`endif
      q.push_back('{2, exp_pc, exp_fl, exp_d});
      lat = F + 2;
    end
    @(negedge clk);
    ret_req = 1;
    @(posedge clk); #1;
    ret_req = 0;
    wait_evt("ret", lat);
  endtask

  initial begin
    #12;
    chk("reset_depth", 32'(depth), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_stk_en", 32'(stk_en), 0);
    chk("reset_pc_out", 32'(pc_out), 0);
    chk("reset_done", 32'(done), 0);
    @(negedge clk); rst_n = 1;
    do_ret();
    do_call(16'hA5C3, 8'h11, 0);
    do_ret();
    do_call(16'h1234, 8'h5A, 0);
    do_ret();
    do_call(16'h0102, 8'h22, 0);
    do_call(16'h0304, 8'h33, 0);
    do_call(16'hBEEF, 8'h44, 0);
    do_ret();
    do_ret();
    do_call(16'h7788, 8'h66, 1);
    do_ret();
    do_ret();
    // abort mid-CALL: only the first two push strobes may appear
    q.push_back('{0, 16'h00BC, 8'h0, 9'h0});
    q.push_back('{0, 16'h009A, 8'h0, 9'h0});
    @(negedge clk);
    call_req = 1; pc_in = 16'h9ABC; flags_in = 8'h77;
    @(posedge clk); #1;
    call_req = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_stk_en", 32'(stk_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_depth", 32'(depth), 0);
    chk("abort_pc_out", 32'(pc_out), 0);
    exp_d = 0; exp_pc = 0; exp_fl = 0;
    pcs.delete(); fls.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    do_call(16'h4242, 8'h5A, 0);
    do_ret();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stack_call_seq.md
# stack_call_seq

Call/return sequencer driving the byte-wide hardware stack of the RNBIP-2 core. On a CALL it splits the 16-bit return PC (optionally plus the flags byte) into single-byte push strobes. On a RET it issues the matching pop strobes and reassembles the returned bytes. It is the initiator side of the stack's `en`/`rw` protocol, sitting between the control unit and the stack pointer/stack RAM, and it tracks stack depth to flag overflow and underflow.

## Interface
- `DEPTH`, default 256: stack capacity in bytes; legal range 4..256.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `call_req` in 1: one-cycle CALL request, sampled only in IDLE.
- `ret_req` in 1: one-cycle RET request, sampled only in IDLE.
- `pc_in` in 16: return address to push, sampled with `call_req`.
- `flags_in` in 8: flags to push, sampled with `call_req` (used only with the macro).
- `stk_rdata` in 8: stack RAM read data, valid the cycle after a pop strobe.
- `stk_en` out 1: stack strobe, one cycle per byte.
- `stk_rw` out 1: 0 = push, 1 = pop; meaningful only while `stk_en`=1.
- `stk_wdata` out 8: push data, valid while `stk_en`=1 and `stk_rw`=0.
- `pc_out` out 16: popped return address.
- `flags_out` out 8: popped flags.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err_ovf` out 1: one-cycle overflow pulse.
- `err_unf` out 1: one-cycle underflow pulse.
- `depth` out 9: current byte count on the stack.

## Operation
- Frame size F is 2 bytes, or 3 with the macro enabled.
- **Push order:** PC[7:0], then PC[15:8], then flags.
- **Pop order:** the exact reverse of push order.
- **State machine states:** IDLE, PUSH_LO, PUSH_HI, PUSH_FL, POP_FL, POP_HI, POP_LO, CAP, FIN.
- **IDLE request handling:**
  - `call_req` with depth+F ≤ DEPTH: latch `pc_in`/`flags_in`, go to PUSH_LO.
  - `call_req` with depth+F > DEPTH: pulse `err_ovf`, stay in IDLE.
  - `ret_req` with depth ≥ F: go to POP_FL (macro on) or POP_HI (macro off).
  - `ret_req` with depth < F: pulse `err_unf`, stay in IDLE.
- **Simultaneous requests:** `call_req` and `ret_req` together means CALL wins and RET is dropped, not queued.
- **Requests while `busy`:** ignored.
- **Push states:** each drives `stk_en`=1, `stk_rw`=0, `stk_wdata` = its byte, and increments depth.
  - Flow is PUSH_LO → PUSH_HI → PUSH_FL (macro on) → FIN.
- **Pop states:** each drives `stk_en`=1, `stk_rw`=1 and decrements depth.
  - Flow is POP_FL → POP_HI → POP_LO → CAP.
  - `stk_rdata` is captured one cycle after each strobe into its destination byte (pipelined).
  - CAP captures the final byte and then goes to FIN.
- **FIN:** pulses `done`, returns to IDLE. `pc_out`/`flags_out` are already updated when `done` is high.
- **Output hold:** `pc_out`/`flags_out` hold their values until the next successful RET completes.
- **Depth arithmetic:** 9-bit unsigned; by construction it never wraps.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, depth is 0. Reset asserted mid-sequence aborts immediately with no further strobes.
- **CALL, request in cycle 0:**
  - Strobes in cycles 1, 2 (and 3 with the macro).
  - `done` in cycle 3 (4 with the macro); `busy` is high from cycle 1 through the `done` cycle.
- **RET, request in cycle 0:**
  - Strobes in cycles 1..F.
  - Data captured in cycles 2..F+1.
  - `done` in cycle F+2.
- **Error pulses:** `err_ovf`/`err_unf` appear in cycle 1. No strobe and no `done` accompany them.
- **Strobe shape:** `stk_en` is never high for two bytes of different direction in the same sequence. Push strobes and pop strobes within one frame are back-to-back.
- **Back-to-back operations:** earliest next request is the cycle after `done` (sampled in IDLE).

## Configuration
- **`STK_FLAGS_SAVE_EN` defined:**
  - F=3.
  - PUSH_FL, POP_FL and `flags_out` capture are active.
- **`STK_FLAGS_SAVE_EN` undefined:**
  - F=2.
  - PUSH_FL and POP_FL are unreachable.
  - `flags_out` is tied to 0 and `flags_in` is ignored.

## Structure
- **Shared package `rnbip_stack_pkg`:** state enum, push/pop encoding constants (PUSH=0, POP=1), frame-size constant derived from the macro.
- **Sub-module:** none required; the depth tracker may be split out as `stack_depth_ctr` (inc/dec, DEPTH bound).

## Test plan
- **Single CALL:** reset, `call_req` with `pc_in`=16'hA5C3 (macro off) → strobes push C3 then A5 in cycles 1–2, `done` in cycle 3, `depth`=2.
- **Round trip:** CALL 16'h1234 then RET, with the stack model returning the bytes → `pc_out`=16'h1234 when `done` is high (cycle 4 after RET), `depth`=0.
- **Nested order:** CALL 16'h0102, CALL 16'h0304, RET, RET → `pc_out` is 16'h0304 then 16'h0102.
- **Overflow:** DEPTH=4, two CALLs, third CALL → `err_ovf` in cycle 1, no `stk_en`, `depth` stays 4.
- **Underflow and priority:**
  - RET on an empty stack → `err_unf`, no `stk_en`.
  - `call_req`+`ret_req` in the same cycle → only the CALL executes.
- **Reset abort and flags:**
  - `rst_n` low during PUSH_HI → outputs 0 immediately, `depth`=0, no further strobes.
  - Macro on: CALL with `flags_in`=8'h5A, then RET → `flags_out`=8'h5A, 3 strobes each way.
